// File: rtl/clock_pkg.sv
// -----------------------------------------------------------------------------
// clock_pkg
// Shared definitions for the time-of-day set controller:
//   - state_e     : controller states (RUN plus one SET state per field)
//   - BLINK_*     : encodings driven on blink_sel
//   - HH_MAX/MS_MAX : highest legal BCD value of the hour / minute-second fields
//   - bcd2_next() : next value of a two-digit BCD counter with a given modulus
//   - blink_for() : blink_sel encoding belonging to a state
// -----------------------------------------------------------------------------
package clock_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_SET_HH = 2'd1,
    ST_SET_MM = 2'd2,
    ST_SET_SS = 2'd3
  } state_e;

  localparam logic [1:0] BLINK_HH   = 2'b00;
  localparam logic [1:0] BLINK_MM   = 2'b01;
  localparam logic [1:0] BLINK_SS   = 2'b10;
  localparam logic [1:0] BLINK_NONE = 2'b11;

  localparam logic [7:0] HH_MAX = 8'h23;
  localparam logic [7:0] MS_MAX = 8'h59;

  // Two-digit BCD increment that wraps to 00 after 'modulus'. BCD ordering
  // matches plain binary ordering, so a magnitude compare is enough; any value
  // at or above the limit also falls back to 00, which keeps the field legal.
  function automatic logic [7:0] bcd2_next(input logic [7:0] v,
                                           input logic [7:0] modulus);
    logic [7:0] r;
    if (v >= modulus) begin
      r = 8'h00;
    end else if (v[3:0] >= 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  function automatic logic [1:0] blink_for(input state_e s);
    logic [1:0] b;
    case (s)
      ST_SET_HH: b = BLINK_HH;
      ST_SET_MM: b = BLINK_MM;
      ST_SET_SS: b = BLINK_SS;
      default:   b = BLINK_NONE;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/time_set_ctrl_if.sv
// -----------------------------------------------------------------------------
// time_set_ctrl_if
// Pulse inputs and display outputs of the time set controller.
//   tick_1hz   : one-cycle pulse per second
//   btn_mode   : debounced pulse, advances the edit mode
//   btn_inc    : debounced pulse, increments the edited field
//   hh/mm/ss   : time as two BCD digits each
//   blink_sel  : field to blink (00 HH, 01 MM, 10 SS, 11 none)
//   set_active : high in any SET state
// Modports: master = pulse source / display sink, slave = the controller.
// -----------------------------------------------------------------------------
interface time_set_ctrl_if;
  logic       tick_1hz;
  logic       btn_mode;
  logic       btn_inc;
  logic [7:0] hh;
  logic [7:0] mm;
  logic [7:0] ss;
  logic [1:0] blink_sel;
  logic       set_active;

  modport master (
    output tick_1hz, btn_mode, btn_inc,
    input  hh, mm, ss, blink_sel, set_active
  );

  modport slave (
    input  tick_1hz, btn_mode, btn_inc,
    output hh, mm, ss, blink_sel, set_active
  );
endinterface

// File: rtl/bcd2_counter.sv
// -----------------------------------------------------------------------------
// bcd2_counter
// Two-digit BCD counter 00..modulus with wrap to 00.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset (clears to 00)
//   inc_en     : advance by one this cycle
//   modulus    : highest value before wrapping (BCD)
//   value      : registered counter value
//   carry_out  : high when inc_en wraps the counter this cycle (combinational)
// -----------------------------------------------------------------------------
module bcd2_counter
  import clock_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc_en,
  input  logic [7:0] modulus,
  output logic [7:0] value,
  output logic       carry_out
);

  logic [7:0] value_q;
  logic [7:0] value_d;

  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    value_d = value_q;
    if (inc_en) begin
      value_d = bcd2_next(value_q, modulus);
    end
  end

  // NOTE: state flops use non-blocking assignments; reset is sampled on the
  // clock edge only (synchronous), so pulses in the reset cycle are dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      value_q <= 8'h00;
    end else begin
      value_q <= value_d;
    end
  end

  assign value     = value_q;
  // Carry is taken from the current value so a whole ss->mm->hh ripple
  // settles within one cycle.
  assign carry_out = inc_en && (value_q == modulus);

endmodule

// File: rtl/time_set_ctrl.sv
// -----------------------------------------------------------------------------
// time_set_ctrl
// Time-of-day keeper with a four-state set mode (RUN, SET_HH, SET_MM, SET_SS).
// In RUN the 1 Hz tick advances ss with carry into mm and hh; in a SET state
// time is frozen and btn_inc bumps only the selected field. btn_mode steps
// through the states and wins over a simultaneous btn_inc.
// Parameters:
//   TIMEOUT_S : idle ticks in a SET state before falling back to RUN (1..15)
// Ports:
//   clk   : system clock
//   rst_n : synchronous active-low reset
//   bus   : time_set_ctrl_if.slave (pulses in, time/blink/set_active out)
// Build option:
//   SET_TIMEOUT_EN : when defined, adds a 4-bit idle counter that returns a
//                    SET state to RUN after TIMEOUT_S ticks without buttons.
// -----------------------------------------------------------------------------
module time_set_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned TIMEOUT_S = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  time_set_ctrl_if.slave bus
);

  if (TIMEOUT_S < 1 || TIMEOUT_S > 15) begin : g_bad_timeout
    $error("time_set_ctrl: TIMEOUT_S must be in 1..15");
  end

  state_e     state_q;
  state_e     state_d;
  logic [1:0] blink_q;
  logic [1:0] blink_d;
  logic       set_active_q;
  logic       set_active_d;

  logic       in_run;
  logic       edit_inc;
  logic       timeout_hit;

  logic       hh_en, mm_en, ss_en;
  logic       ss_carry, mm_carry;
  logic       day_carry_unused;  // midnight wrap has no consumer
  logic [7:0] hh_val, mm_val, ss_val;

  assign in_run   = (state_q == ST_RUN);
  // btn_mode discards a btn_inc arriving in the same cycle.
  assign edit_inc = !in_run && bus.btn_inc && !bus.btn_mode;

  // -------------------------------------------------------------------------
  // Enable / carry steering: the tick ripples through all fields in RUN,
  // a button press touches only the selected field in SET.
  // -------------------------------------------------------------------------
  always_comb begin
    ss_en = 1'b0;
    mm_en = 1'b0;
    hh_en = 1'b0;
    if (in_run) begin
      ss_en = bus.tick_1hz;
      mm_en = ss_carry;
      hh_en = mm_carry;
    end else begin
      ss_en = edit_inc && (state_q == ST_SET_SS);
      mm_en = edit_inc && (state_q == ST_SET_MM);
      hh_en = edit_inc && (state_q == ST_SET_HH);
    end
  end

  bcd2_counter u_ss (
    .clk       (clk),
    .rst_n     (rst_n),
    .inc_en    (ss_en),
    .modulus   (MS_MAX),
    .value     (ss_val),
    .carry_out (ss_carry)
  );

  bcd2_counter u_mm (
    .clk       (clk),
    .rst_n     (rst_n),
    .inc_en    (mm_en),
    .modulus   (MS_MAX),
    .value     (mm_val),
    .carry_out (mm_carry)
  );

  bcd2_counter u_hh (
    .clk       (clk),
    .rst_n     (rst_n),
    .inc_en    (hh_en),
    .modulus   (HH_MAX),
    .value     (hh_val),
    .carry_out (day_carry_unused)
  );

  // -------------------------------------------------------------------------
  // Optional idle timeout. The counter is held at zero in RUN and cleared by
  // any button, so entering a SET state (always via btn_mode) starts at zero.
  // -------------------------------------------------------------------------
`ifdef SET_TIMEOUT_EN
  logic [3:0] to_cnt_q;
  logic [3:0] to_cnt_d;

  always_comb begin
    to_cnt_d    = to_cnt_q;
    timeout_hit = 1'b0;
    if (in_run || bus.btn_mode || bus.btn_inc) begin
      to_cnt_d = 4'd0;
    end else if (bus.tick_1hz) begin
      if (to_cnt_q == 4'(TIMEOUT_S - 1)) begin
        timeout_hit = 1'b1;
        to_cnt_d    = 4'd0;
      end else begin
        to_cnt_d = to_cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      to_cnt_q <= 4'd0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // FSM with registered blink_sel / set_active derived from the next state.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (bus.btn_mode) begin
      case (state_q)
        ST_RUN:    state_d = ST_SET_HH;
        ST_SET_HH: state_d = ST_SET_MM;
        ST_SET_MM: state_d = ST_SET_SS;
        ST_SET_SS: state_d = ST_RUN;
        default:   state_d = ST_RUN;
      endcase
    end else if (timeout_hit) begin
      state_d = ST_RUN;
    end
    blink_d      = blink_for(state_d);
    set_active_d = (state_d != ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_RUN;
      blink_q      <= BLINK_NONE;
      set_active_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      blink_q      <= blink_d;
      set_active_q <= set_active_d;
    end
  end

  assign bus.hh         = hh_val;
  assign bus.mm         = mm_val;
  assign bus.ss         = ss_val;
  assign bus.blink_sel  = blink_q;
  assign bus.set_active = set_active_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// -----------------------------------------------------------------------------
// tb_time_set_ctrl
// Bench for time_set_ctrl: a vector table from reset, directed sequences for
// the multi-cycle corners, then random pulses against a reference model that
// keeps the time as seconds-of-day and the mode as a plain integer.
// Honours SET_TIMEOUT_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_time_set_ctrl;

  localparam int TO = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  time_set_ctrl_if bus ();

  time_set_ctrl #(.TIMEOUT_S(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic check_out(input string tag, input logic [7:0] hh, input logic [7:0] mm,
                           input logic [7:0] ss, input logic [1:0] blink, input logic set);
    check({tag, ".hh"}, {24'd0, bus.hh}, {24'd0, hh});
    check({tag, ".mm"}, {24'd0, bus.mm}, {24'd0, mm});
    check({tag, ".ss"}, {24'd0, bus.ss}, {24'd0, ss});
    check({tag, ".blink"}, {30'd0, bus.blink_sel}, {30'd0, blink});
    check({tag, ".set"}, {31'd0, bus.set_active}, {31'd0, set});
  endtask

  // One clock: drive at the falling edge, sample 1 time unit after rising edge.
  task automatic step(input logic r, input logic t, input logic mo, input logic in);
    @(negedge clk);
    rst_n = r; bus.tick_1hz = t; bus.btn_mode = mo; bus.btn_inc = in;
    @(posedge clk);
    #1;
    rst_n = 1'b1; bus.tick_1hz = 1'b0; bus.btn_mode = 1'b0; bus.btn_inc = 1'b0;
  endtask

  task automatic steps(input int n, input logic t, input logic mo, input logic in);
    for (int i = 0; i < n; i++) step(1'b1, t, mo, in);
  endtask

  // ---------------- reference model ----------------
  int m_md, m_h, m_m, m_s, m_idle;  // m_md: 0 RUN, 1 HH, 2 MM, 3 SS

  task automatic model_step(input logic r, input logic t, input logic mo, input logic in);
    int nxt, tod;
    if (!r) begin
      m_md = 0; m_h = 0; m_m = 0; m_s = 0; m_idle = 0;
      return;
    end
    nxt = m_md;
    if (m_md == 0) begin
      if (t) begin
        tod = (m_h * 3600 + m_m * 60 + m_s + 1) % 86400;
        m_h = tod / 3600; m_m = (tod / 60) % 60; m_s = tod % 60;
      end
      if (mo) nxt = 1;
    end else begin
      if (mo) nxt = (m_md == 3) ? 0 : m_md + 1;
      else if (in) begin
        if (m_md == 1) m_h = (m_h + 1) % 24;
        else if (m_md == 2) m_m = (m_m + 1) % 60;
        else m_s = (m_s + 1) % 60;
      end
`ifdef SET_TIMEOUT_EN
      if (mo || in) m_idle = 0;
      else if (t) begin
        m_idle++;
        if (m_idle == TO) begin nxt = 0; m_idle = 0; end
      end
`endif
    end
    m_md = nxt;
  endtask

  function automatic logic [7:0] to_bcd(input int n);
    return {4'(n / 10), 4'(n % 10)};
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic r, t, mo, in;
    logic [7:0] hh, mm, ss;
    logic [1:0] blink;
    logic set;
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic r, t, mo, in;
    bus.tick_1hz = 1'b0; bus.btn_mode = 1'b0; bus.btn_inc = 1'b0;

    //          r  t  mo in  hh     mm     ss     blink  set
    vecs[0]  = '{0, 1, 1, 1, 8'h00, 8'h00, 8'h00, 2'b11, 1'b0}; // pulses during reset ignored
    vecs[1]  = '{1, 1, 0, 0, 8'h00, 8'h00, 8'h01, 2'b11, 1'b0}; // first tick after reset
    vecs[2]  = '{1, 0, 0, 1, 8'h00, 8'h00, 8'h01, 2'b11, 1'b0}; // inc ignored in RUN
    vecs[3]  = '{1, 1, 1, 0, 8'h00, 8'h00, 8'h02, 2'b00, 1'b1}; // tick + mode in RUN
    vecs[4]  = '{1, 1, 0, 0, 8'h00, 8'h00, 8'h02, 2'b00, 1'b1}; // frozen in SET_HH
    vecs[5]  = '{1, 0, 0, 1, 8'h01, 8'h00, 8'h02, 2'b00, 1'b1};
    vecs[6]  = '{1, 0, 1, 1, 8'h01, 8'h00, 8'h02, 2'b01, 1'b1}; // mode beats inc
    vecs[7]  = '{1, 0, 0, 1, 8'h01, 8'h01, 8'h02, 2'b01, 1'b1};
    vecs[8]  = '{1, 0, 1, 0, 8'h01, 8'h01, 8'h02, 2'b10, 1'b1};
    vecs[9]  = '{1, 0, 0, 1, 8'h01, 8'h01, 8'h03, 2'b10, 1'b1};
    vecs[10] = '{1, 0, 1, 0, 8'h01, 8'h01, 8'h03, 2'b11, 1'b0};
    vecs[11] = '{1, 1, 0, 0, 8'h01, 8'h01, 8'h04, 2'b11, 1'b0};

    step(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      step(vecs[i].r, vecs[i].t, vecs[i].mo, vecs[i].in);
      check_out($sformatf("vec%0d", i), vecs[i].hh, vecs[i].mm, vecs[i].ss,
                vecs[i].blink, vecs[i].set);
    end

    // 23:59:59 -> 00:00:00 on a single tick
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    steps(23, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    steps(59, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    steps(59, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    check_out("preload", 8'h23, 8'h59, 8'h59, 2'b11, 1'b0);
    step(1'b1, 1'b1, 1'b0, 0);
    check_out("midnight", 8'h00, 8'h00, 8'h00, 2'b11, 1'b0);

    // hour wrap by 25 incs, ticks frozen in SET_HH
    step(1'b0, 1'b0, 1'b0, 1'b0);
    steps(5, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    steps(25, 1'b0, 1'b0, 1'b1);
    steps(3, 1'b1, 1'b0, 1'b0);
    check_out("hh_wrap", 8'h01, 8'h00, 8'h05, 2'b00, 1'b1);

    // SET_MM at 59: inc + mode together
    step(1'b1, 1'b0, 1'b1, 1'b0);
    steps(59, 1'b0, 1'b0, 1'b1);
    check_out("mm59", 8'h01, 8'h59, 8'h05, 2'b01, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    check_out("mm_mode_inc", 8'h01, 8'h59, 8'h05, 2'b10, 1'b1);

    // Idle timeout in SET_SS
    steps(9, 1'b1, 1'b0, 1'b0);
    check_out("to_9", 8'h01, 8'h59, 8'h05, 2'b10, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    steps(9, 1'b1, 1'b0, 1'b0);
    check_out("to_inc9", 8'h01, 8'h59, 8'h06, 2'b10, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0);
`ifdef SET_TIMEOUT_EN
    check_out("to_10", 8'h01, 8'h59, 8'h06, 2'b11, 1'b0);
`else
    check_out("to_10", 8'h01, 8'h59, 8'h06, 2'b10, 1'b1);
`endif

    // Reset in the middle of editing
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    steps(42, 1'b0, 1'b0, 1'b1);
    check_out("mm42", 8'h00, 8'h42, 8'h00, 2'b01, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    check_out("edit_reset", 8'h00, 8'h00, 8'h00, 2'b11, 1'b0);

    // Random pulses against the reference model
    step(1'b0, 1'b0, 1'b0, 1'b0);
    model_step(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 199) != 0);
      t  = ($urandom_range(0, 3) == 0);
      mo = ($urandom_range(0, 15) == 0);
      in = ($urandom_range(0, 2) == 0);
      step(r, t, mo, in);
      model_step(r, t, mo, in);
      check_out("rand", to_bcd(m_h), to_bcd(m_m), to_bcd(m_s),
                (m_md == 0) ? 2'b11 : 2'(m_md - 1), (m_md != 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/time_set_ctrl.md
TIME_SET_CTRL -- requirements
Module: time_set_ctrl

Interface
REQ-001 Parameter: TIMEOUT_S, 10, number of tick_1hz pulses with no button activity after which a SET state returns to RUN; range 1..15.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 tick_1hz  input  1  one-cycle pulse, once per second.
REQ-005 btn_mode  input  1  debounced one-cycle pulse; advances the edit mode.
REQ-006 btn_inc  input  1  debounced one-cycle pulse; increments the field being edited.
REQ-007 hh  output  8  hours as two BCD digits {tens, units}, 00..23.
REQ-008 mm  output  8  minutes as two BCD digits, 00..59.
REQ-009 ss  output  8  seconds as two BCD digits, 00..59.
REQ-010 blink_sel  output  2  field to blink: 00 = HH, 01 = MM, 10 = SS, 11 = none.
REQ-011 set_active  output  1  high while in any SET state.

Function
REQ-012 The FSM SHALL have four states: RUN, SET_HH, SET_MM and SET_SS.
REQ-013 On btn_mode the state SHALL advance RUN -> SET_HH -> SET_MM -> SET_SS -> RUN, one step per pulse.
REQ-014 In RUN, tick_1hz SHALL increment ss; the ss 59->00 rollover SHALL carry into mm, and the mm 59->00 rollover SHALL carry into hh. All of this SHALL happen in the same cycle, so time 23:59:59 becomes 00:00:00 on one tick.
REQ-015 In RUN, btn_inc SHALL be ignored.
REQ-016 In a SET state, tick_1hz SHALL NOT advance the time, so the time is frozen while editing.
REQ-017 In a SET state, btn_inc SHALL increment only the selected field: hh wraps 23->00, mm and ss wrap 59->00, with no carry into any other field.
REQ-018 If btn_mode and btn_inc arrive in the same cycle, btn_mode SHALL take effect and btn_inc SHALL be discarded.
REQ-019 If tick_1hz and btn_mode arrive in the same cycle while in RUN, the tick SHALL be applied and the state SHALL still advance to SET_HH.
REQ-020 Outputs SHALL be registered; a field or state change SHALL be visible on the outputs in the cycle after the input pulse (1-cycle latency).
REQ-021 blink_sel SHALL be 00 in SET_HH, 01 in SET_MM, 10 in SET_SS and 11 in RUN.
REQ-022 set_active SHALL be high exactly when the state is not RUN.
REQ-023 hh, mm and ss SHALL always hold valid BCD within range; no digit SHALL ever exceed 9.

Reset
REQ-024 While rst_n is sampled low at a clk edge, the block SHALL set: state = RUN, hh = 8'h00, mm = 8'h00, ss = 8'h00, blink_sel = 2'b11, set_active = 0, and the timeout counter to 0.
REQ-025 A reset in the middle of editing SHALL discard the edit and return to RUN with time 00:00:00.
REQ-026 Pulses that arrive in the reset cycle SHALL be ignored.

Configuration
REQ-027 Macro SET_TIMEOUT_EN defined: a 4-bit counter SHALL clear on every SET-state entry and on every btn_mode or btn_inc pulse, and SHALL count tick_1hz pulses while in a SET state.
REQ-028 Macro SET_TIMEOUT_EN defined: on the tick that brings the count to TIMEOUT_S, the next state SHALL be RUN and the edited values SHALL be kept.
REQ-029 Macro SET_TIMEOUT_EN defined: a btn_mode in that same cycle SHALL take precedence over the timeout.
REQ-030 Macro SET_TIMEOUT_EN undefined: no counter SHALL exist, and SET states SHALL be left only via btn_mode or reset.

Structure
REQ-031 The package clock_pkg SHALL hold:
- the state enum;
- the blink_sel encodings (BLINK_HH, BLINK_MM, BLINK_SS, BLINK_NONE);
- the BCD limit constants HH_MAX = 8'h23 and MS_MAX = 8'h59.
REQ-032 Sub-module bcd2_counter SHALL be a two-digit BCD counter with:
- a modulus input, an increment enable and a carry-out;
- three instances, one each for hh, mm and ss.
REQ-033 time_set_ctrl SHALL contain only the FSM, the enable/carry steering and the optional timeout counter.

Verification
REQ-034 Reset, then a tick in the cycle after rst_n goes high -> ss = 8'h01 one cycle later; blink_sel = 11; set_active = 0.
REQ-035 Preload 23:59:59 in RUN, then one tick -> 00:00:00 one cycle later.
REQ-036 btn_mode x1, then btn_inc x25 -> state SET_HH, hh = 8'h01 (wrapped at 23), mm and ss unchanged; ticks during SET_HH leave ss frozen.
REQ-037 In SET_MM at mm = 8'h59, btn_inc and btn_mode in the same cycle -> state SET_SS, mm stays 8'h59, blink_sel = 10.
REQ-038 With SET_TIMEOUT_EN and TIMEOUT_S = 10 in SET_SS:
- 9 ticks, then btn_inc, then 10 ticks -> RUN on the 10th tick after btn_inc, ss incremented by 1, set_active = 0;
- without the macro, the same sequence stays in SET_SS.
REQ-039 rst_n low for one cycle while in SET_MM with mm = 8'h42 -> RUN with 00:00:00 and blink_sel = 11 on the next cycle.
